shift_arbiter: RTL
==================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; only 32 is supported, matching the shared Shifter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports req0 / req1, input, 1 each, shift request from requester 0 / 1.
REQ-005 SHALL have ports data0A / data1A, input, 32 each, value to be shifted left.
REQ-006 SHALL have ports amt0 / amt1, input, 5 each, shift amount 0..31.
REQ-007 SHALL have ports ack0 / ack1, output, 1 each, one-cycle pulse: operands captured.
REQ-008 SHALL have ports done0 / done1, output, 1 each, one-cycle pulse: dataOut valid for that requester.
REQ-009 SHALL have port dataOut, output, 32, registered shift result.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 SHALL instantiate exactly one Shifter; its dataA is driven from opA_r and dataB from {27'b0, amt_r}.
REQ-012 SHALL implement states IDLE, EXEC and DONE, encoded in 2 bits.
REQ-013 SHALL, in IDLE with no request, remain in IDLE.
REQ-014 SHALL, in IDLE with any request, capture the winner's operands into opA_r/amt_r, set owner_r, and go to EXEC.
REQ-015 SHALL, in EXEC, assert ack[owner_r], load dataOut from the Shifter output at the clock edge, and go to DONE.
REQ-016 SHALL, in DONE, assert done[owner_r] and go to IDLE unconditionally.
REQ-017 SHALL give a latency of 3 edges from the sampled request to the done pulse; maximum throughput is one operation per 3 cycles.
REQ-018 SHALL hold dataOut stable outside the EXEC-to-DONE edge, so it remains valid until the next operation completes.
REQ-019 SHALL require the requester to hold req and operands until ack; if req is still high in the next IDLE, it is a new request.
REQ-020 SHALL ignore operand changes after capture; the in-flight result uses the captured values.
REQ-021 SHALL give dataOut = data << amt, truncated to 32 bits; amt=0 passes data unchanged and amt=31 leaves only bit 0 in bit 31.
REQ-022 SHALL never assert ack0 and ack1 together, nor done0 and done1 together.
REQ-023 SHALL ignore a request arriving in EXEC or DONE until IDLE.

Reset
REQ-024 SHALL, on rst high, immediately force state=IDLE, ack0/1=0, done0/1=0, dataOut=0, busy=0, opA_r=0, amt_r=0, owner_r=0, last_r=1.
REQ-025 SHALL, on reset mid-operation, abandon the operation with no ack or done issued afterwards; the requester must re-request.
REQ-026 SHALL accept a request on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with SHIFT_ARB_RR_EN defined, use round-robin: when both req0 and req1 are high in IDLE, grant the port that is not last_r, and update last_r to each grant.
REQ-028 SHALL, without SHIFT_ARB_RR_EN, use fixed priority where port 0 always wins and last_r is unused.
REQ-029 SHALL grant a sole requester immediately in both configurations.

Verification
REQ-030 SHALL cover: req0, data0A=32'h0000_0001, amt0=5 -> ack0 in EXEC, then done0 with dataOut=32'h0000_0020, 3 edges after the request.
REQ-031 SHALL cover: req1, data1A=32'hFFFF_FFFF, amt1=31 -> dataOut=32'h8000_0000 with done1; amt1=0 -> dataOut=32'hFFFF_FFFF.
REQ-032 SHALL cover: req0 and req1 held high for 4 operations with RR -> grant order 0,1,0,1; without the macro -> 0,0,0,0 (port 1 starved while req0 high).
REQ-033 SHALL cover: rst asserted during EXEC -> outputs 0 in the same cycle, no done pulse, next request serviced normally with a correct result.
REQ-034 SHALL cover: data0A changed to 32'h1234_5678 in the cycle after capture of 32'h0000_00FF with amt0=4 -> dataOut=32'h0000_0FF0.
REQ-035 SHALL cover: req1 raised during EXEC of a port-0 operation -> no ack1 until IDLE, then port 1 is serviced with done1 3 edges later.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester arbiter sharing one left Shifter; a three-state IDLE/EXEC/DONE sequence per operation.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

module Shifter #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] result
);

  assign result = dataA << dataB;

endmodule

module shift_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0A,
  input  logic [DATA_W-1:0] data1A,
  input  logic [4:0]        amt0,
  input  logic [4:0]        amt1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] dataOut,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] opA_r;
  logic [4:0]        amt_r;
  logic              owner_r;
  logic              grant;
  logic              anyReq;
  logic [DATA_W-1:0] shiftOut;

  assign anyReq = req0 | req1;

`ifdef SHIFT_ARB_RR_EN
  logic last_r;

  // On contention the port that did not win last time is served.
  always_comb begin
    grant = req1;
    if (req0 && req1) grant = ~last_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (state == IDLE && anyReq) begin
      last_r <= grant;
    end
  end
`else
  always_comb begin
    grant = ~req0;
  end
`endif

  Shifter #(.DATA_W(DATA_W)) uShifter (
    .dataA  (opA_r),
    .dataB  ({{(DATA_W-5){1'b0}}, amt_r}),
    .result (shiftOut)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      opA_r   <= '0;
      amt_r   <= '0;
      owner_r <= 1'b0;
      dataOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            opA_r   <= grant ? data1A : data0A;
            amt_r   <= grant ? amt1 : amt0;
            owner_r <= grant;
            state   <= EXEC;
          end
        end
        EXEC: begin
          dataOut <= shiftOut;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake pulses decode straight from state so reset clears them immediately.
  always_comb begin
    ack0  = (state == EXEC) && !owner_r;
    ack1  = (state == EXEC) &&  owner_r;
    done0 = (state == DONE) && !owner_r;
    done1 = (state == DONE) &&  owner_r;
    busy  = (state != IDLE);
  end

endmodule
